// File: rtl/icu_nested.sv
// Nested interrupt control unit: maskable edge/level channels with fixed-priority
// in-service nesting and an o_intr / i_inta vector handshake.
module icu_nested #(
  parameter int               CHANNELS  = 8,
  parameter int               VEC_W     = 8,
  parameter logic [VEC_W-1:0] VBASE_RST = 8'h20
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_interrupt,
  input  logic                i_cs,
  input  logic                i_we,
  input  logic [2:0]          i_addr,
  input  logic [CHANNELS-1:0] i_data,
  output logic [CHANNELS-1:0] o_rdata,
  input  logic                i_inta,
  output logic                o_intr,
  output logic [VEC_W-1:0]    o_vector
);

  localparam int IW = 6;

  typedef enum logic {IDLE, ACK} state_t;

  state_t              state_reg, state_next;
  logic [CHANNELS-1:0] mask_reg, mode_reg, pend_reg, isr_reg, prev_reg;
  logic [VEC_W-1:0]    vbase_reg;
  logic                inta_d_reg;

  logic                wr, eoi_wr, inta_rise;
  logic [CHANNELS-1:0] eff_pend, req, isr_lowest, isr_eoi, isr_next, pend_next, w1c, ack_clr;
  logic [IW-1:0]       win, top;
  logic                req_any, isr_any, valid, ack_go, spurious, intr_next;

  assign wr        = i_cs & i_we;
  assign eoi_wr    = wr && (i_addr == 3'd5);
  assign inta_rise = i_inta & ~inta_d_reg;

  // Level channels bypass the pend flop and present the raw line directly.
  assign eff_pend   = (pend_reg & mode_reg) | (i_interrupt & ~mode_reg);
  assign req        = eff_pend & ~mask_reg;
  assign isr_lowest = isr_reg & (~isr_reg + CHANNELS'(1));

  always_comb begin
    isr_eoi = isr_reg;
    if (eoi_wr) begin
      if (i_data == '0) isr_eoi = isr_reg & ~isr_lowest;
      else              isr_eoi = isr_reg & ~i_data;
    end
  end

  // Priority encoders; the winner is judged against the post-EOI in-service set.
  always_comb begin
    win = '0;
    top = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i])     win = IW'(i);
      if (isr_eoi[i]) top = IW'(i);
    end
    req_any = |req;
    isr_any = |isr_eoi;
    valid   = req_any && (!isr_any || (win < top));
  end

  always_comb begin
    state_next = state_reg;
    ack_go     = 1'b0;
    spurious   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (inta_rise) begin
          if (valid) begin
            ack_go     = 1'b1;
            state_next = ACK;
          end else begin
            spurious = 1'b1;
          end
        end
      end
      ACK: begin
        if (!i_inta) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    intr_next = valid && !ack_go && (state_next == IDLE);
  end

  // Clears are applied before the new-edge set so a coincident edge survives.
  always_comb begin
    w1c       = (wr && (i_addr == 3'd2)) ? i_data : '0;
    ack_clr   = ack_go ? (CHANNELS'(1) << win) : '0;
    pend_next = ((pend_reg & ~w1c & ~ack_clr) | (i_interrupt & ~prev_reg)) & mode_reg;
    isr_next  = isr_eoi | ack_clr;
  end

  always_comb begin
    o_rdata = '0;
    if (i_cs && !i_we) begin
      case (i_addr)
        3'd0:    o_rdata = mask_reg;
        3'd1:    o_rdata = mode_reg;
        3'd2:    o_rdata = eff_pend;
        3'd3:    o_rdata = isr_reg;
        3'd4:    o_rdata = CHANNELS'(vbase_reg);
        default: o_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_reg   <= '1;
      mode_reg   <= '0;
      vbase_reg  <= VBASE_RST;
      pend_reg   <= '0;
      isr_reg    <= '0;
      prev_reg   <= '0;
      inta_d_reg <= 1'b0;
      o_intr     <= 1'b0;
      o_vector   <= '0;
    end else begin
      if (wr && i_addr == 3'd0) mask_reg  <= i_data;
      if (wr && i_addr == 3'd1) mode_reg  <= i_data;
      if (wr && i_addr == 3'd4) vbase_reg <= VEC_W'(i_data);
      pend_reg   <= pend_next;
      isr_reg    <= isr_next;
      prev_reg   <= i_interrupt;
      inta_d_reg <= i_inta;
      o_intr     <= intr_next;
      if (ack_go)        o_vector <= vbase_reg + VEC_W'(win);
      else if (spurious) o_vector <= vbase_reg + VEC_W'(CHANNELS);
    end
  end

endmodule

// File: tb/tb_icu_nested.sv
// Self-checking bench for icu_nested: acknowledged vectors go through a scoreboard queue.
module tb_icu_nested;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] i_interrupt = '0;
  logic       i_cs = 1'b0, i_we = 1'b0;
  logic [2:0] i_addr = '0;
  logic [7:0] i_data = '0;
  logic [7:0] o_rdata;
  logic       i_inta = 1'b0;
  logic       o_intr;
  logic [7:0] o_vector;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rv;

  icu_nested #(.CHANNELS(8), .VEC_W(8), .VBASE_RST(8'h20)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_interrupt(i_interrupt),
    .i_cs(i_cs), .i_we(i_we), .i_addr(i_addr), .i_data(i_data),
    .o_rdata(o_rdata), .i_inta(i_inta), .o_intr(o_intr), .o_vector(o_vector)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_data = d;
    tick();
    i_cs = 1'b0; i_we = 1'b0; i_data = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    i_cs = 1'b1; i_we = 1'b0; i_addr = a;
    #1;
    d = o_rdata;
    i_cs = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    i_interrupt = i_interrupt | bits;
    tick();
    i_interrupt = i_interrupt & ~bits;
  endtask

  // Raise i_inta for one edge, compare the vector against the scoreboard, then drop it.
  task automatic ack(input string name);
    logic [7:0] exp_v;
    i_inta = 1'b1;
    tick();
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s: scoreboard empty, vector=%02h", name, o_vector);
    end else begin
      exp_v = exp_q.pop_front();
      if (o_vector !== exp_v) begin errors++; $display("FAIL %s vector: got %02h want %02h", name, o_vector, exp_v); end
      else $display("ack %s vector %02h", name, o_vector);
    end
    checks++;
    if (o_intr !== 1'b0) begin errors++; $display("FAIL %s intr_after_ack: got %b want 0", name, o_intr); end
    i_inta = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick(3);
    checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL rst_intr: got %b want 0", o_intr); end
    checks++; if (o_vector !== 8'h00) begin errors++; $display("FAIL rst_vector: got %02h want 00", o_vector); end
    rd(3'd0, rv); checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL rst_mask: got %02h want ff", rv); end
    rd(3'd1, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rst_mode: got %02h want 00", rv); end
    rd(3'd4, rv); checks++; if (rv !== 8'h20) begin errors++; $display("FAIL rst_vbase: got %02h want 20", rv); end
    rd(3'd3, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rst_isr: got %02h want 00", rv); end
    i_rst_n = 1'b1;
    tick();
    $display("reset checked");
  endtask

  task automatic test_basic_edge();
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    pulse(8'h01);
    checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL basic_latency1: got %b want 0", o_intr); end
    tick();
    checks++; if (o_intr !== 1'b1) begin errors++; $display("FAIL basic_latency2: got %b want 1", o_intr); end
    exp_q.push_back(8'h20);
    ack("basic");
    rd(3'd3, rv); checks++; if (rv !== 8'h01) begin errors++; $display("FAIL basic_isr: got %02h want 01", rv); end
    wr(3'd5, 8'h00);
    rd(3'd3, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL basic_eoi: got %02h want 00", rv); end
  endtask

  task automatic test_nesting();
    wr(3'd1, 8'hFF);
    pulse(8'h08);
    tick();
    exp_q.push_back(8'h23);
    ack("nest_ch3");
    rd(3'd3, rv); checks++; if (rv !== 8'h08) begin errors++; $display("FAIL nest_isr3: got %02h want 08", rv); end
    pulse(8'h20);
    tick(3);
    checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL nest_ch5_blocked: got %b want 0", o_intr); end
    pulse(8'h02);
    tick();
    checks++; if (o_intr !== 1'b1) begin errors++; $display("FAIL nest_ch1_intr: got %b want 1", o_intr); end
    exp_q.push_back(8'h21);
    ack("nest_ch1");
    rd(3'd3, rv); checks++; if (rv !== 8'h0A) begin errors++; $display("FAIL nest_isr31: got %02h want 0a", rv); end
    wr(3'd5, 8'h00);
    rd(3'd3, rv); checks++; if (rv !== 8'h08) begin errors++; $display("FAIL nest_eoi_top: got %02h want 08", rv); end
    tick();
    checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL nest_ch5_still_blocked: got %b want 0", o_intr); end
    wr(3'd5, 8'h08);
    tick();
    exp_q.push_back(8'h25);
    ack("nest_ch5");
    wr(3'd5, 8'h00);
    rd(3'd3, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL nest_final_isr: got %02h want 00", rv); end
  endtask

  task automatic test_level();
    wr(3'd1, 8'h00);
    wr(3'd0, 8'hFB);
    i_interrupt[2] = 1'b1;
    tick();
    checks++; if (o_intr !== 1'b1) begin errors++; $display("FAIL level_intr: got %b want 1", o_intr); end
    rd(3'd2, rv); checks++; if (rv !== 8'h04) begin errors++; $display("FAIL level_pend: got %02h want 04", rv); end
    wr(3'd0, 8'hFF);
    tick();
    checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL level_masked: got %b want 0", o_intr); end
    i_interrupt[2] = 1'b0;
    tick();
    rd(3'd2, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL level_pend_low: got %02h want 00", rv); end
  endtask

  task automatic test_simultaneous();
    wr(3'd1, 8'hFF);
    wr(3'd0, 8'h00);
    pulse(8'h44);
    tick();
    rd(3'd2, rv); checks++; if (rv !== 8'h44) begin errors++; $display("FAIL sim_pend: got %02h want 44", rv); end
    exp_q.push_back(8'h22);
    ack("sim_ch2");
    wr(3'd5, 8'h00);
    tick();
    exp_q.push_back(8'h26);
    ack("sim_ch6");
    wr(3'd5, 8'h00);
    rd(3'd2, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL sim_pend_clear: got %02h want 00", rv); end
  endtask

  task automatic test_spurious_wrap();
    wr(3'd0, 8'hFF);
    pulse(8'h10);
    tick();
    exp_q.push_back(8'h28);
    ack("spurious");
    rd(3'd3, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL spur_isr: got %02h want 00", rv); end
    wr(3'd2, 8'h10);
    wr(3'd4, 8'hFC);
    wr(3'd0, 8'h7F);
    pulse(8'h80);
    tick();
    exp_q.push_back(8'h03);
    ack("wrap_ch7");
    rd(3'd3, rv); checks++; if (rv !== 8'h80) begin errors++; $display("FAIL wrap_isr: got %02h want 80", rv); end
    wr(3'd5, 8'h00);
    wr(3'd4, 8'h20);
  endtask

  task automatic test_reset_in_ack();
    wr(3'd0, 8'h00);
    pulse(8'h01);
    tick();
    i_inta = 1'b1;
    tick();
    rd(3'd3, rv); checks++; if (rv !== 8'h01) begin errors++; $display("FAIL rack_isr_pre: got %02h want 01", rv); end
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_intr !== 1'b0) begin errors++; $display("FAIL rack_intr: got %b want 0", o_intr); end
    checks++; if (o_vector !== 8'h00) begin errors++; $display("FAIL rack_vector: got %02h want 00", o_vector); end
    rd(3'd3, rv); checks++; if (rv !== 8'h00) begin errors++; $display("FAIL rack_isr: got %02h want 00", rv); end
    rd(3'd0, rv); checks++; if (rv !== 8'hFF) begin errors++; $display("FAIL rack_mask: got %02h want ff", rv); end
    i_inta = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    $display("reset during ack checked");
  endtask

  initial begin
    test_reset();
    test_basic_edge();
    test_nesting();
    test_level();
    test_simultaneous();
    test_spurious_wrap();
    test_reset_in_ack();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icu_nested.md
Name: icu_nested

Overview:
- Parametrised interrupt control unit; successor to the fixed 8-line ICU.
- Collects CHANNELS interrupt lines and applies per-channel masking and per-channel edge/level mode.
- Fixed-priority nesting via an in-service register; presents a vector to the CPU through the o_intr / i_inta handshake.
- Sits on the CPU peripheral bus (cs/we/addr/data); drives the CPU interrupt input.

Parameters:
CHANNELS, 8, number of interrupt lines (1..32); channel 0 is highest priority
VEC_W, 8, vector width
VBASE_RST, 8'h20, reset value of the vector base register

Ports:
i_clk  in  1  system clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_interrupt  in  CHANNELS  raw interrupt lines, synchronous to i_clk
i_cs  in  1  register chip select
i_we  in  1  write enable, qualified by i_cs
i_addr  in  3  register address
i_data  in  CHANNELS  write data (VBASE uses low VEC_W bits)
o_rdata  out  CHANNELS  read data, combinational
i_inta  in  1  interrupt acknowledge from CPU, level
o_intr  out  1  interrupt request to CPU, registered
o_vector  out  VEC_W  acknowledged vector, registered

Behaviour:
- Registers, written on a clock edge with i_cs&i_we:
  - 0 MASK: rw; 1 = masked; reset all 1s.
  - 1 MODE: rw; 1 = rising-edge, 0 = level; reset 0.
  - 2 PEND: read; write-1-to-clear edge-latched bits.
  - 3 ISR: read-only; in-service bits; reset 0.
  - 4 VBASE: rw, low VEC_W bits; reset VBASE_RST.
  - 5 EOI: write-only.
    - Data 0 clears the highest-priority set ISR bit.
    - Nonzero data clears the ISR bits where data=1.
  - 6, 7: reserved; read 0, writes ignored.
- Read path:
  - o_rdata = selected register when i_cs&~i_we, else 0.
  - Reading PEND returns the effective pending vector.
- Edge detection:
  - prev register holds i_interrupt delayed one cycle; reset 0.
  - Edge channel: pend bit sets when i_interrupt & ~prev.
  - Level channel: effective pending = i_interrupt (pend flop unused, held 0).
- Request:
  - req = eff_pend & ~MASK.
  - win = lowest-index set bit of req.
  - top = lowest-index set bit of ISR.
  - o_intr next = (req != 0) && (ISR == 0 || win < top), i.e. only strictly higher priority nests.
- Acknowledge FSM with states IDLE and ACK:
  - inta_rise = i_inta & ~inta_d. Only a rising i_inta acts; holding it high does nothing further.
  - On inta_rise with a valid win (same nesting rule as o_intr):
    - ISR[win] set.
    - Edge pend[win] cleared.
    - o_vector <= VBASE + win, modulo 2^VEC_W.
    - o_intr <= 0 next cycle.
    - State goes to ACK.
  - On inta_rise with no valid request (spurious):
    - o_vector <= VBASE + CHANNELS.
    - ISR unchanged.
  - ACK returns to IDLE when i_inta goes low.
  - o_intr is forced 0 while in ACK.
  - o_vector holds until the next acknowledge.
- Latency:
  - Input edge at cycle n → pend set at n+1 → o_intr high at n+2.
  - Level input → o_intr high one cycle after the input is high.
- Simultaneous events:
  - New edge and a PEND W1C on the same bit: set wins.
  - EOI write and inta_rise in the same cycle: EOI applies first; the winner is computed against the post-EOI ISR.
  - Acknowledge clear and a new edge on the same channel: pend stays set.
  - A MASK write affects o_intr in the following cycle.
- Reset (any time, including mid-acknowledge):
  - State IDLE.
  - o_intr 0, o_vector 0.
  - pend, ISR, prev, inta_d all 0.
  - MASK all 1s, MODE 0, VBASE VBASE_RST.

Test Plan:
- Reset, then write MASK=0, MODE=0x01. Pulse i_interrupt[0] for 1 cycle → o_intr=1 two cycles later; assert i_inta → o_vector=0x20, ISR=0x01, o_intr=0; EOI write 0 → ISR=0x00.
- Nesting: ch3 acknowledged (ISR=0x08), then ch1 edge → o_intr=1 and ack gives vector 0x21, ISR=0x0A. A ch5 request while ISR=0x08 keeps o_intr=0.
- Level mode: MODE=0, hold i_interrupt[2]=1 with MASK=0xFB → o_intr=1. Set MASK=0xFF → o_intr=0 next cycle. PEND reads 0x04 while the input is high.
- Simultaneous edges on ch2 and ch6 → first ack vector VBASE+2. After EOI, second ack vector VBASE+6.
- Spurious: i_inta rise with all channels masked → o_vector=VBASE+CHANNELS (0x28), ISR unchanged. VBASE=0xFC with ack of ch7 → o_vector=0x03 (wrap).
- Assert i_rst_n low while in ACK with ISR=0x01 → immediately o_intr=0, o_vector=0, ISR=0, MASK=0xFF. Verify via o_rdata reads.
